mips_mem_loader: RTL and testbench

Unified instruction/data memory responder for the multicycle `mips` core: answers the core's `adr`/`writedata`/`memwrite`/`readdata` bus. It also owns a byte-stream program loader that holds the core in reset while a program image is streamed in, then releases it. One memory-mapped output register gives programs a visible result and a write strobe. Sits beside `mips` at top level; it replaces a preloaded ROM/RAM model.

---
 rtl/mem_pkg.sv | 25 ++
 rtl/mips_mem_loader_if.sv | 25 ++
 rtl/byte_packer.sv | 55 +++++
 rtl/mips_mem_loader.sv | 143 ++++++++++++++
 tb/tb_mips_mem_loader.sv | 244 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
// Shared types and constants for the MIPS memory responder and its program loader.
package mem_pkg;

  typedef enum logic [1:0] {
    WAIT_START = 2'd0,
    LOAD       = 2'd1,
    RUN        = 2'd2
  } ld_state_t;

  localparam logic [31:0] DEFAULT_MMIO_ADDR = 32'h0000_FFFC;
  localparam logic [31:0] ZERO_WORD         = 32'h0000_0000;

  // Lane 0 is the most significant byte: the stream is big-endian.
  function automatic logic [31:0] place_byte(input logic [1:0] lane, input logic [7:0] b);
    logic [31:0] w;
    case (lane)
      2'd0:    w = {b, 24'h0};
      2'd1:    w = {8'h0, b, 16'h0};
      2'd2:    w = {16'h0, b, 8'h0};
      default: w = {24'h0, b};
    endcase
    return w;
  endfunction

endpackage

// File: rtl/mips_mem_loader_if.sv
// Core memory bus plus loader byte stream; master is the core/loader side, slave is the memory.
interface mips_mem_loader_if;

  logic [31:0] adr;
  logic [31:0] writedata;
  logic        memwrite;
  logic [31:0] readdata;

  logic        ld_start;
  logic        ld_valid;
  logic [7:0]  ld_data;
  logic        ld_last;
  logic        ld_ready;

  modport master (
    output adr, writedata, memwrite, ld_start, ld_valid, ld_data, ld_last,
    input  readdata, ld_ready
  );

  modport slave (
    input  adr, writedata, memwrite, ld_start, ld_valid, ld_data, ld_last,
    output readdata, ld_ready
  );

endinterface

// File: rtl/byte_packer.sv
// Assembles accepted loader bytes into big-endian 32-bit words; a last byte flushes a
// partial word with its missing low bytes zero-filled.
module byte_packer
  import mem_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  input  logic        in_last,
  output logic [31:0] word,
  output logic        word_valid,
  output logic        partial
);

  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] asm_q, asm_d;
  logic [31:0] merged;

  assign merged     = asm_q | place_byte(cnt_q, in_data);
  assign word       = merged;
  assign word_valid = in_valid & ((cnt_q == 2'd3) | in_last);
  assign partial    = in_valid & in_last & (cnt_q != 2'd3);

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
    cnt_d = cnt_q;
    asm_d = asm_q;
    if (clear) begin
      cnt_d = 2'd0;
      asm_d = ZERO_WORD;
    end else if (in_valid) begin
      if (word_valid) begin
        cnt_d = 2'd0;
        asm_d = ZERO_WORD;
      end else begin
        cnt_d = cnt_q + 2'd1;
        asm_d = merged;
      end
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= 2'd0;
      asm_q <= ZERO_WORD;
    end else begin
      cnt_q <= cnt_d;
      asm_q <= asm_d;
    end
  end

endmodule

// File: rtl/mips_mem_loader.sv
// Unified instruction/data RAM for the multicycle MIPS core, with a byte-stream program
// loader that holds the core in reset while an image streams in, plus one MMIO output register.
module mips_mem_loader
  import mem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 64,
  parameter logic [31:0] MMIO_ADDR   = DEFAULT_MMIO_ADDR,
  localparam int         ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              reset,
  mips_mem_loader_if.slave  bus,
  output logic              cpu_reset,
  output logic              ld_error,
  output logic [ADDR_W:0]   ld_words,
  output logic [31:0]       io_out,
  output logic              io_strobe
);

  localparam logic [ADDR_W:0] FULL_PTR = (ADDR_W + 1)'(DEPTH_WORDS);

  ld_state_t         state_q, state_d;
  logic              cpu_reset_q, cpu_reset_d;
  logic              ld_error_q, ld_error_d;
  logic [ADDR_W:0]   wptr_q, wptr_d;
  logic [31:0]       io_out_q, io_out_d;
  logic              io_strobe_q, io_strobe_d;

  logic [31:0]       mem_q [DEPTH_WORDS];

  logic              ld_ready, accept, enter_load;
  logic [31:0]       pk_word;
  logic              pk_valid, pk_partial;
  logic              ptr_full, ld_write;
  logic              in_ram, is_mmio, core_we;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata;
  logic              unused_adr_lsbs;

  assign ld_ready   = (state_q == LOAD);
  assign accept     = bus.ld_valid & ld_ready;
  assign enter_load = bus.ld_start & (state_q != LOAD);

  byte_packer u_packer (
    .clk        (clk),
    .reset      (reset),
    .clear      (enter_load),
    .in_valid   (accept),
    .in_data    (bus.ld_data),
    .in_last    (bus.ld_last),
    .word       (pk_word),
    .word_valid (pk_valid),
    .partial    (pk_partial)
  );

  assign ptr_full = (wptr_q == FULL_PTR);
  assign ld_write = pk_valid & ~ptr_full;

  always_comb begin
    state_d = state_q;
    case (state_q)
      WAIT_START: if (bus.ld_start) state_d = LOAD;
      LOAD:       if (accept && bus.ld_last) state_d = RUN;
      RUN:        if (bus.ld_start) state_d = LOAD;
      default:    state_d = WAIT_START;
    endcase
    // The core leaves reset on the very edge that accepts the final byte.
    cpu_reset_d = (state_d != RUN);
  end

  always_comb begin
    wptr_d     = wptr_q;
    ld_error_d = ld_error_q;
    if (enter_load) begin
      wptr_d     = '0;
      ld_error_d = 1'b0;
    end else if (pk_valid) begin
      if (ptr_full) ld_error_d = 1'b1;
      else          wptr_d     = wptr_q + (ADDR_W + 1)'(1);
      if (pk_partial) ld_error_d = 1'b1;
    end
  end

  assign in_ram          = (bus.adr[31:ADDR_W+2] == '0);
  assign is_mmio         = (bus.adr[31:2] == MMIO_ADDR[31:2]);
  assign core_we         = bus.memwrite & ~cpu_reset_q;
  assign unused_adr_lsbs = ^bus.adr[1:0];

  always_comb begin
    io_out_d    = io_out_q;
    io_strobe_d = 1'b0;
    if (core_we && is_mmio) begin
      io_out_d    = bus.writedata;
      io_strobe_d = 1'b1;
    end
  end

  // Loader and core never write together: the loader only writes in LOAD, the core only in RUN.
  always_comb begin
    ram_we    = ld_write | (core_we & in_ram);
    ram_addr  = ld_write ? wptr_q[ADDR_W-1:0] : bus.adr[ADDR_W+1:2];
    ram_wdata = ld_write ? pk_word : bus.writedata;
  end

  always_comb begin
    bus.readdata = ZERO_WORD;
    if (in_ram)       bus.readdata = mem_q[bus.adr[ADDR_W+1:2]];
    else if (is_mmio) bus.readdata = io_out_q;
  end

  assign bus.ld_ready = ld_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= WAIT_START;
      cpu_reset_q <= 1'b1;
      ld_error_q  <= 1'b0;
      wptr_q      <= '0;
      io_out_q    <= ZERO_WORD;
      io_strobe_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cpu_reset_q <= cpu_reset_d;
      ld_error_q  <= ld_error_d;
      wptr_q      <= wptr_d;
      io_out_q    <= io_out_d;
      io_strobe_q <= io_strobe_d;
    end
  end

  // NOTE: the RAM array has no reset; its contents survive a reset so a reload can be partial.
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[ram_addr] <= ram_wdata;
  end

  assign cpu_reset = cpu_reset_q;
  assign ld_error  = ld_error_q;
  assign ld_words  = wptr_q;
  assign io_out    = io_out_q;
  assign io_strobe = io_strobe_q;

endmodule

// File: tb/tb_mips_mem_loader.sv
// Scoreboard bench for mips_mem_loader (DEPTH_WORDS=4): stimulus queues expectations, a
// negedge monitor compares reads, status, MMIO strobes and core-release events.
module tb_mips_mem_loader;

  localparam int DEPTH = 4;
  localparam int AW    = $clog2(DEPTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          cpu_reset;
  logic          ld_error;
  logic [AW:0]   ld_words;
  logic [31:0]   io_out;
  logic          io_strobe;

  mips_mem_loader_if bus ();

  mips_mem_loader #(.DEPTH_WORDS(DEPTH)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .cpu_reset (cpu_reset),
    .ld_error  (ld_error),
    .ld_words  (ld_words),
    .io_out    (io_out),
    .io_strobe (io_strobe)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // {cpu_reset, ld_ready, ld_error, ld_words}
  logic [31:0] status;
  assign status = {26'b0, cpu_reset, bus.ld_ready, ld_error, ld_words};

  bit          probe_kind_q [$];  // 1: status, 0: readdata
  logic [31:0] probe_exp_q  [$];
  string       probe_name_q [$];
  logic [31:0] strobe_exp_q [$];
  logic [31:0] rel_exp_q    [$];
  int          rel_cyc_q    [$];
  string       rel_name_q   [$];

  logic        probe_en = 1'b0;
  logic        cpu_reset_prev = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  bit          mon_kind;
  logic [31:0] mon_exp;
  string       mon_name;
  int          mon_cyc;

  always @(negedge clk) begin
    if (probe_en && probe_exp_q.size() > 0) begin
      mon_kind = probe_kind_q.pop_front();
      mon_exp  = probe_exp_q.pop_front();
      mon_name = probe_name_q.pop_front();
      check(mon_name, mon_kind ? status : bus.readdata, mon_exp);
    end
    if (io_strobe === 1'b1) begin
      if (strobe_exp_q.size() == 0) check("unexpected_io_strobe", {31'b0, io_strobe}, 32'd0);
      else check("io_out_on_strobe", io_out, strobe_exp_q.pop_front());
    end
    if (cpu_reset_prev === 1'b1 && cpu_reset === 1'b0) begin
      if (rel_exp_q.size() == 0) check("unexpected_release", {31'b0, cpu_reset}, 32'd1);
      else begin
        mon_exp  = rel_exp_q.pop_front();
        mon_cyc  = rel_cyc_q.pop_front();
        mon_name = rel_name_q.pop_front();
        check({mon_name, "_cycle"}, 32'(cyc), 32'(mon_cyc));
        check({mon_name, "_status"}, status, mon_exp);
      end
    end
    cpu_reset_prev <= cpu_reset;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic probe_rd(input logic [31:0] a, input logic [31:0] exp, input string name);
    bus.adr = a;
    probe_kind_q.push_back(1'b0);
    probe_exp_q.push_back(exp);
    probe_name_q.push_back(name);
    probe_en = 1'b1;
    tick();
    probe_en = 1'b0;
  endtask

  task automatic probe_st(input logic [31:0] exp, input string name);
    probe_kind_q.push_back(1'b1);
    probe_exp_q.push_back(exp);
    probe_name_q.push_back(name);
    probe_en = 1'b1;
    tick();
    probe_en = 1'b0;
  endtask

  task automatic start();
    bus.ld_start = 1'b1;
    tick();
    bus.ld_start = 1'b0;
  endtask

  task automatic send(input logic [7:0] b, input logic last);
    bus.ld_valid = 1'b1;
    bus.ld_data  = b;
    bus.ld_last  = last;
    tick();
    bus.ld_valid = 1'b0;
    bus.ld_last  = 1'b0;
  endtask

  // Called right after the edge that accepted the final byte; the release must carry that cycle.
  task automatic expect_release(input logic [31:0] st, input string name);
    rel_exp_q.push_back(st);
    rel_cyc_q.push_back(cyc);
    rel_name_q.push_back(name);
  endtask

  task automatic core_wr(input logic [31:0] a, input logic [31:0] d);
    bus.adr       = a;
    bus.writedata = d;
    bus.memwrite  = 1'b1;
    tick();
    bus.memwrite  = 1'b0;
  endtask

  logic [7:0] prog [8] = '{8'h20, 8'h08, 8'h00, 8'h05, 8'hAC, 8'h02, 8'h00, 8'hFC};
  logic [7:0] part [6] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4, 8'hB1, 8'hB2};

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    reset         = 1'b1;
    bus.adr       = '0;
    bus.writedata = '0;
    bus.memwrite  = 1'b0;
    bus.ld_start  = 1'b0;
    bus.ld_valid  = 1'b0;
    bus.ld_data   = '0;
    bus.ld_last   = 1'b0;
    repeat (2) tick();
    reset = 1'b0;

    // Idle after reset: core held, loader not ready, MMIO clear.
    probe_st(32'h20, "reset_status");
    probe_rd(32'h0000_FFFC, 32'h0, "reset_io_out");
    repeat (5) tick();
    probe_st(32'h20, "idle_status");

    // Two-word program.
    start();
    probe_st(32'h30, "load_entry_status");
    for (int i = 0; i < 8; i++) send(prog[i], i == 7);
    expect_release(32'h02, "prog_release");
    probe_rd(32'h0, 32'h2008_0005, "prog_word0");
    probe_rd(32'h4, 32'hAC02_00FC, "prog_word1");
    probe_st(32'h02, "prog_run_status");

    // Core traffic in RUN.
    strobe_exp_q.push_back(32'h0000_0007);
    core_wr(32'h0000_FFFC, 32'h0000_0007);
    probe_rd(32'h0000_FFFE, 32'h7, "mmio_read_lsb_ignored");
    probe_rd(32'h0000_8000, 32'h0, "unmapped_read");
    probe_rd(32'h0000_0010, 32'h0, "past_ram_read");
    core_wr(32'h0000_0008, 32'h1234_5678);
    probe_rd(32'h0000_000A, 32'h1234_5678, "core_store_readback");
    core_wr(32'h0000_8000, 32'h0000_0055);
    probe_rd(32'h0000_8000, 32'h0, "unmapped_store_ignored");

    // Reset in the middle of a reload.
    start();
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    send(8'h33, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    probe_st(32'h20, "midload_reset_status");
    core_wr(32'h0, 32'hFFFF_FFFF);
    core_wr(32'h0000_FFFC, 32'h0000_0009);
    probe_rd(32'h0, 32'h2008_0005, "held_store_ignored");
    probe_rd(32'h4, 32'hAC02_00FC, "ram_kept_over_reset");
    probe_rd(32'h0000_FFFC, 32'h0, "io_out_cleared_by_reset");

    // Six-byte load: partial final word.
    start();
    for (int i = 0; i < 6; i++) send(part[i], i == 5);
    expect_release(32'h0A, "partial_release");
    probe_rd(32'h0, 32'hA1A2_A3A4, "partial_word0");
    probe_rd(32'h4, 32'hB1B2_0000, "partial_word1");
    probe_rd(32'h8, 32'h1234_5678, "partial_word2_untouched");

    // Five words into a four-word RAM; ld_start mid-load must be ignored.
    start();
    probe_st(32'h30, "error_cleared_on_start");
    for (int i = 1; i <= 20; i++) begin
      if (i == 6) bus.ld_start = 1'b1;
      send(8'(i), i == 20);
      bus.ld_start = 1'b0;
      if (i == 16) probe_st(32'h34, "full_before_overflow");
    end
    expect_release(32'h0C, "overflow_release");
    probe_rd(32'h0, 32'h0102_0304, "ovf_word0");
    probe_rd(32'h4, 32'h0506_0708, "ovf_word1");
    probe_rd(32'h8, 32'h090A_0B0C, "ovf_word2");
    probe_rd(32'hC, 32'h0D0E_0F10, "ovf_word3");

    // Single-byte load.
    start();
    send(8'h5A, 1'b1);
    expect_release(32'h09, "single_release");
    probe_rd(32'h0, 32'h5A00_0000, "single_word0");
    probe_rd(32'h4, 32'h0506_0708, "single_word1_untouched");

    repeat (2) tick();
    check("probes_pending", 32'(probe_exp_q.size()), 32'd0);
    check("strobes_pending", 32'(strobe_exp_q.size()), 32'd0);
    check("releases_pending", 32'(rel_exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
